// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter: shares one SDRAM application port between a write
// requester (UDP ingress FIFO) and a read requester (frame readback).
// Whole bursts of BURST_LEN words are granted round-robin. Defining
// ARB_WR_PRIORITY_EN makes the write side win every contention instead.
// sdr_init_done is registered once before arbitration, so a grant appears
// two cycles after it rises.
module sdram_burst_arbiter #(
  parameter int unsigned ADDR_W    = 21,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 512
) (
  input  logic              ext_mem_clk,
  input  logic              rst_n,
  input  logic              sdr_init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic              wr_grant,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_base,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_done,
  output logic              App_wr_en,
  output logic [ADDR_W-1:0] App_wr_addr,
  output logic [1:0]        App_wr_dm,
  output logic [DATA_W-1:0] App_wr_din,
  output logic              App_rd_en,
  output logic [ADDR_W-1:0] App_rd_addr,
  input  logic              App_rd_valid,
  input  logic [DATA_W-1:0] App_rd_dout
);

  localparam int unsigned   CntW     = 13;
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(BURST_LEN);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [2:0] {StIdle, StWrBurst, StRdIssue, StRdDrain, StGap} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CntW-1:0]     beat_q, beat_d;
  logic [CntW-1:0]     ret_q, ret_d;
  logic                init_q;
  logic                last_wr_q, last_wr_d;  // last_served: 1 = write, 0 = read
  logic                cur_wr_q, cur_wr_d;    // side owning the current burst
  logic                pick_wr, grant_any;
  logic                ret_hit, ret_last, issue_last, in_read;
  logic [ADDR_W-1:0]   beat_addr;

  logic                wr_en_q, wr_done_q, rd_valid_q, rd_done_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_din_q, rd_data_q;

  assign beat_addr  = addr_q + ADDR_W'(beat_q);  // wraps modulo 2^ADDR_W
  assign issue_last = (beat_q == LastBeat);
  assign in_read    = (state_q == StRdIssue) || (state_q == StRdDrain);
  // Returns beyond a full burst are not counted; stray valids outside a read are dropped.
  assign ret_hit    = App_rd_valid && in_read && (ret_q < FullCnt);
  assign ret_last   = ret_hit && (ret_q == LastBeat);

  // Arbitration decision for the IDLE state.
  always_comb begin
    grant_any = init_q && (wr_req || rd_req);
`ifdef ARB_WR_PRIORITY_EN
    pick_wr = wr_req;
`else
    pick_wr = wr_req && (!rd_req || !last_wr_q);
`endif
  end

  // Next-state logic for the burst FSM and its counters.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    ret_d     = ret_q;
    last_wr_d = last_wr_q;
    cur_wr_d  = cur_wr_q;
    if (ret_hit) begin
      ret_d = ret_q + CntOne;
    end
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          addr_d   = pick_wr ? wr_base : rd_base;
          beat_d   = '0;
          ret_d    = '0;
          cur_wr_d = pick_wr;
          state_d  = pick_wr ? StWrBurst : StRdIssue;
        end
      end
      StWrBurst: begin
        beat_d = beat_q + CntOne;
        if (issue_last) begin
          state_d = StGap;
        end
      end
      StRdIssue: begin
        beat_d = beat_q + CntOne;
        if (issue_last) begin
          state_d = (ret_last || (ret_q == FullCnt)) ? StGap : StRdDrain;
        end
      end
      StRdDrain: begin
        if (ret_last) begin
          state_d = StGap;
        end
      end
      StGap: begin
        last_wr_d = cur_wr_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, burst address/counters and arbitration history.
  always_ff @(posedge ext_mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      beat_q    <= '0;
      ret_q     <= '0;
      init_q    <= 1'b0;
      last_wr_q <= 1'b0;
      cur_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      ret_q     <= ret_d;
      init_q    <= sdr_init_done;
      last_wr_q <= last_wr_d;
      cur_wr_q  <= cur_wr_d;
    end
  end

  // Registered write strobes and read return path (one cycle after pop / App_rd_valid).
  always_ff @(posedge ext_mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_din_q   <= '0;
      wr_done_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_done_q  <= 1'b0;
    end else begin
      wr_en_q    <= wr_pop;
      wr_done_q  <= wr_pop && issue_last;
      rd_valid_q <= ret_hit;
      rd_done_q  <= ret_last;
      if (wr_pop) begin
        wr_addr_q <= beat_addr;
        wr_din_q  <= wr_data;
      end
      if (ret_hit) begin
        rd_data_q <= App_rd_dout;
      end
    end
  end

  assign wr_pop      = (state_q == StWrBurst);
  assign wr_grant    = (state_q == StWrBurst);
  assign rd_grant    = in_read;
  assign App_rd_en   = (state_q == StRdIssue);
  assign App_rd_addr = App_rd_en ? beat_addr : '0;
  assign App_wr_en   = wr_en_q;
  assign App_wr_addr = wr_addr_q;
  assign App_wr_din  = wr_din_q;
  assign App_wr_dm   = 2'b00;
  assign wr_done     = wr_done_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_done     = rd_done_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Bench for sdram_burst_arbiter: FIFO/SDRAM models plus directed-random steps.
module tb_sdram_burst_arbiter;
  localparam int unsigned AW  = 21;
  localparam int unsigned DW  = 32;
  localparam int unsigned BL  = 4;
  localparam int unsigned LAT = 7;

  logic          ext_mem_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sdr_init_done = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_base = '0, rd_base = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_pop, wr_grant, wr_done, rd_grant, rd_valid, rd_done;
  logic [DW-1:0] rd_data, App_wr_din, App_rd_dout;
  logic          App_wr_en, App_rd_en, App_rd_valid;
  logic [AW-1:0] App_wr_addr, App_rd_addr;
  logic [1:0]    App_wr_dm;

  always #5 ext_mem_clk = ~ext_mem_clk;

  sdram_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .ext_mem_clk(ext_mem_clk), .rst_n(rst_n), .sdr_init_done(sdr_init_done),
    .wr_req(wr_req), .wr_base(wr_base), .wr_data(wr_data), .wr_pop(wr_pop),
    .wr_grant(wr_grant), .wr_done(wr_done), .rd_req(rd_req), .rd_base(rd_base),
    .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .App_wr_en(App_wr_en), .App_wr_addr(App_wr_addr), .App_wr_dm(App_wr_dm),
    .App_wr_din(App_wr_din), .App_rd_en(App_rd_en), .App_rd_addr(App_rd_addr),
    .App_rd_valid(App_rd_valid), .App_rd_dout(App_rd_dout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- write FIFO model (FWFT) ----------------
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] exp_wr[$];
  logic          pop_pend = 1'b0;

  always @(negedge ext_mem_clk) pop_pend = wr_pop;
  always @(posedge ext_mem_clk) begin
    #1;
    if (pop_pend && fifo.size() > 0) fifo.delete(0);
    pop_pend = 1'b0;
    wr_data = (fifo.size() > 0) ? fifo[0] : '0;
  end

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fifo.push_back(w);
      exp_wr.push_back(w);
    end
    wr_data = fifo[0];
  endtask

  // ---------------- SDRAM read model: fixed latency, data derived from address ----------------
  logic [DW-1:0] rd_seed = '0;
  logic          stray_v = 1'b0;
  logic [DW-1:0] stray_d = '0;
  logic          pv[LAT+1];
  logic [DW-1:0] pd[LAT+1];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input logic [DW-1:0] s);
    return (DW'(a) * 32'h9E37_79B1) ^ s;
  endfunction

  initial for (int k = 0; k <= LAT; k++) begin pv[k] = 1'b0; pd[k] = '0; end

  always @(negedge ext_mem_clk) begin
    for (int k = LAT; k > 0; k--) begin pv[k] = pv[k-1]; pd[k] = pd[k-1]; end
    pv[0] = App_rd_en && rst_n;
    pd[0] = mem_word(App_rd_addr, rd_seed);
    if (!rst_n) for (int k = 0; k <= LAT; k++) pv[k] = 1'b0;
  end

  assign App_rd_valid = pv[LAT] | stray_v;
  assign App_rd_dout  = stray_v ? stray_d : (pv[LAT] ? pd[LAT] : '0);

  // ---------------- monitor ----------------
  logic [AW-1:0] ob_wa[$];
  logic [DW-1:0] ob_wd[$];
  logic          ob_wdone[$];
  logic [AW-1:0] ob_ra[$];
  logic [DW-1:0] ob_rd[$];
  logic          ob_rdone[$];
  logic [7:0]    gr_seq[$];
  int            gaps[$];
  int n_wr_done = 0, n_rd_done = 0, n_rd_valid = 0, n_strobe = 0, n_overlap = 0;
  int n_orphan = 0, low_run = 0;
  logic pw = 1'b0, pr = 1'b0;

  always @(negedge ext_mem_clk) begin
    if (!rst_n) begin
      pw = 1'b0; pr = 1'b0; low_run = 0;
    end else begin
      if (App_wr_en) begin ob_wa.push_back(App_wr_addr); ob_wd.push_back(App_wr_din);
                           ob_wdone.push_back(wr_done); end
      if (App_rd_en) ob_ra.push_back(App_rd_addr);
      if (rd_valid) begin ob_rd.push_back(rd_data); ob_rdone.push_back(rd_done); n_rd_valid++; end
      if (wr_done) n_wr_done++;
      if (rd_done) n_rd_done++;
      if ((wr_done && !App_wr_en) || (rd_done && !rd_valid)) n_orphan++;
      if (App_wr_en || App_rd_en || wr_pop || wr_grant || rd_grant) n_strobe++;
      if (wr_grant && rd_grant) n_overlap++;
      if (wr_grant && !pw) begin gr_seq.push_back("W"); gaps.push_back(low_run); end
      if (rd_grant && !pr) begin gr_seq.push_back("R"); gaps.push_back(low_run); end
      low_run = (wr_grant || rd_grant) ? 0 : low_run + 1;
      pw = wr_grant; pr = rd_grant;
    end
  end

  task automatic clear_mon();
    ob_wa.delete(); ob_wd.delete(); ob_wdone.delete(); ob_ra.delete();
    ob_rd.delete(); ob_rdone.delete(); gr_seq.delete(); gaps.delete(); exp_wr.delete();
    n_wr_done = 0; n_rd_done = 0; n_rd_valid = 0; n_strobe = 0; n_overlap = 0; n_orphan = 0;
  endtask

  task automatic step();
    @(negedge ext_mem_clk);
    #1;
  endtask

  function automatic int sel_cnt(input int sel);
    case (sel)
      0:       return n_wr_done;
      1:       return n_rd_done;
      2:       return gr_seq.size();
      default: return ob_wa.size();
    endcase
  endfunction

  task automatic wait_until(input int sel, input int target, input int limit, input string tag);
    int i = 0;
    while (sel_cnt(sel) < target && i < limit) begin step(); i++; end
    check(tag, 128'(sel_cnt(sel) >= target), 128'(1));
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({wr_pop, wr_grant, wr_done, rd_grant, rd_valid, rd_data, rd_done, App_wr_en,
                 App_wr_addr, App_wr_dm, App_wr_din, App_rd_en, App_rd_addr});
  endfunction

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] b, input int i);
    return AW'((longint'(b) + longint'(i)) % (longint'(1) << AW));
  endfunction

  // Write beats observed since clear_mon: address = base + (i mod BL), data = FIFO order.
  task automatic check_writes(input string tag, input logic [AW-1:0] base, input int beats);
    check({tag, "_beats"}, 128'(ob_wa.size()), 128'(beats));
    for (int i = 0; i < beats && i < ob_wa.size(); i++) begin
      check({tag, "_addr"}, 128'(ob_wa[i]), 128'(wrap_add(base, i % BL)));
      check({tag, "_din"}, 128'(ob_wd[i]), 128'(exp_wr[i]));
      check({tag, "_done"}, 128'(ob_wdone[i]), 128'((i % BL) == BL - 1));
    end
  endtask

  task automatic check_reads(input string tag, input logic [AW-1:0] base, input int words);
    check({tag, "_issues"}, 128'(ob_ra.size()), 128'(words));
    check({tag, "_returns"}, 128'(ob_rd.size()), 128'(words));
    for (int i = 0; i < words && i < ob_ra.size(); i++)
      check({tag, "_raddr"}, 128'(ob_ra[i]), 128'(wrap_add(base, i % BL)));
    for (int i = 0; i < words && i < ob_rd.size(); i++) begin
      check({tag, "_rdata"}, 128'(ob_rd[i]), 128'(mem_word(wrap_add(base, i % BL), rd_seed)));
      check({tag, "_rdone"}, 128'(ob_rdone[i]), 128'((i % BL) == BL - 1));
    end
  endtask

  logic [7:0]    exp_seq[4];
  logic [AW-1:0] b;
  int            cnt;
  int            n_w;

  initial begin
    // reset state
    repeat (3) step();
    check("reset_outs", all_outs(), 128'(0));
    @(posedge ext_mem_clk); #1 rst_n = 1'b1;
    step();
    check("post_reset_idle", all_outs(), 128'(0));

    // 1: single write burst
    sdr_init_done = 1'b1;
    clear_mon();
    push_words(BL);
    wr_base = 21'h000100;
    wr_req = 1'b1;
    wait_until(0, 1, 60, "t1_wr_done_seen");
    wr_req = 1'b0;
    repeat (6) step();
    check_writes("t1", 21'h000100, BL);
    check("t1_grants", 128'(gr_seq.size()), 128'(1));
    check("t1_fifo_empty", 128'(fifo.size()), 128'(0));
    check("t1_orphan_done", 128'(n_orphan), 128'(0));

    // 2: read burst wrapping the top of the address space
    clear_mon();
    rd_seed = $urandom;
    rd_base = 21'h1FFFFE;
    rd_req = 1'b1;
    wait_until(1, 1, 80, "t2_rd_done_seen");
    rd_req = 1'b0;
    repeat (LAT + 6) step();
    check_reads("t2", 21'h1FFFFE, BL);
    check("t2_orphan_done", 128'(n_orphan), 128'(0));

    // 6: stray App_rd_valid in IDLE, then a normal read
    clear_mon();
    for (int i = 0; i < 3; i++) begin stray_d = $urandom; stray_v = 1'b1; step(); end
    stray_v = 1'b0;
    repeat (3) step();
    check("t6_stray_dropped", 128'(n_rd_valid), 128'(0));
    rd_seed = $urandom;
    b = AW'($urandom_range(0, (1 << AW) - 1));
    rd_base = b;
    rd_req = 1'b1;
    wait_until(1, 1, 80, "t6_rd_done_seen");
    rd_req = 1'b0;
    repeat (20) step();
    check_reads("t6", b, BL);

    // 3: both requests held -> alternation (or write priority)
    clear_mon();
    push_words(4 * BL);
    b = AW'($urandom_range(0, (1 << AW) - 1));
    wr_base = b;
    rd_base = AW'($urandom_range(0, (1 << AW) - 1));
    rd_seed = $urandom;
    wr_req = 1'b1; rd_req = 1'b1;
    wait_until(2, 4, 400, "t3_four_grants");
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (40) step();
`ifdef ARB_WR_PRIORITY_EN
    exp_seq = '{"W", "W", "W", "W"};
`else
    exp_seq = '{"W", "R", "W", "R"};
`endif
    n_w = 0;
    for (int i = 0; i < 4; i++) if (exp_seq[i] == "W") n_w++;
    for (int i = 0; i < 4 && i < gr_seq.size(); i++)
      check("t3_grant_order", 128'(gr_seq[i]), 128'(exp_seq[i]));
    for (int i = 1; i < 4 && i < gaps.size(); i++)
      check("t3_gap_cycles", 128'(gaps[i]), 128'(2));
    check("t3_overlap", 128'(n_overlap), 128'(0));
    check_writes("t3", b, n_w * BL);
    check("t3_read_returns", 128'(ob_rd.size()), 128'((4 - n_w) * BL));
    fifo.delete(); wr_data = '0;

    // 4: init_done low blocks grants; grant two cycles after it rises
    sdr_init_done = 1'b0;
    step();
    clear_mon();
    push_words(BL);
    b = AW'($urandom_range(0, (1 << AW) - 1));
    wr_base = b;
    wr_req = 1'b1; rd_req = 1'b1;
    repeat (100) step();
    check("t4_no_activity", 128'(n_strobe), 128'(0));
    check("t4_no_grant", 128'(gr_seq.size()), 128'(0));
    sdr_init_done = 1'b1;
    cnt = 0;
    while (!(wr_grant || rd_grant) && cnt < 20) begin step(); cnt++; end
    check("t4_grant_latency", 128'(cnt), 128'(2));
    check("t4_write_granted", 128'({wr_grant, rd_grant}), 128'(2'b10));
    rd_req = 1'b0;
    wait_until(0, 1, 60, "t4_wr_done_seen");
    wr_req = 1'b0;
    repeat (6) step();
    check_writes("t4", b, BL);

    // 5: reset during beat 2 of a write burst
    clear_mon();
    push_words(BL);
    wr_base = AW'($urandom_range(0, (1 << AW) - 1));
    wr_req = 1'b1;
    wait_until(3, 2, 60, "t5_two_beats_seen");
    rst_n = 1'b0;
    #1;
    check("t5_async_zero", all_outs(), 128'(0));
    fifo.delete(); wr_req = 1'b0; wr_data = '0;
    repeat (2) step();
    check("t5_held_zero", all_outs(), 128'(0));
    @(posedge ext_mem_clk); #1 rst_n = 1'b1;
    clear_mon();
    b = AW'($urandom_range(0, (1 << AW) - 1));
    wr_base = b;
    push_words(BL);
    wr_req = 1'b1;
    wait_until(0, 1, 60, "t5_wr_done_seen");
    wr_req = 1'b0;
    repeat (6) step();
    check_writes("t5", b, BL);
    check("t5_dm", 128'(App_wr_dm), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
